l2_ahb_err_slave: RTL
=====================

# l2_ahb_err_slave

Parametrised AHB default/error slave for the L2 AHB matrix. It answers every NONSEQ/SEQ transfer decoded to an unmapped region with the full two-cycle AHB ERROR response, after a programmable number of wait states. It also logs the first faulting address for debug, counts faults and raises an interrupt. IDLE/BUSY transfers get a zero-wait OKAY.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of HADDR and ERR_ADDR
- WAIT_STATES, 0, wait cycles inserted before the ERROR response; legal range 0..15
- CNT_WIDTH, 8, width of the saturating fault counter ERR_CNT

Ports:
- HCLK  in  1  AHB clock; all state changes on rising edge
- HRESET  in  1  reset; one clock; reset is asynchronous and active-high
- HSEL  in  1  slave select from the matrix decoder
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ
- HREADY  in  1  bus-level transfer done
- HADDR  in  ADDR_WIDTH  address phase address
- HWRITE  in  1  address phase direction
- HREADYOUT  out  1  ready feedback to the matrix
- HRESP  out  2  response: 2'b00 OKAY, 2'b01 ERROR
- ERR_CLR  in  1  synchronous clear of the log, one-cycle pulse
- ERR_VALID  out  1  a fault has been captured since the last clear
- ERR_ADDR  out  ADDR_WIDTH  HADDR of the first captured fault
- ERR_WRITE  out  1  HWRITE of the first captured fault
- ERR_OVF  out  1  at least one further fault occurred while ERR_VALID was set
- ERR_CNT  out  CNT_WIDTH  faults since the last clear, saturating at all-ones
- ERR_IRQ  out  1  level interrupt; equals ERR_VALID

## Operation
- Fault accept: `acc = HSEL & HREADY & HTRANS[1]`, sampled only in IDLE or ERR2. In any other state the inputs are ignored.
- Response FSM, with a 4-bit wait counter `wcnt`:
  - IDLE: HREADYOUT=1, HRESP=OKAY. On acc, go to WAIT with `wcnt=WAIT_STATES-1` if WAIT_STATES>0; otherwise go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=OKAY. If `wcnt==0`, go to ERR1; otherwise decrement `wcnt`.
  - ERR1: HREADYOUT=0, HRESP=ERROR. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR. On acc, take the same entry as from IDLE (back-to-back faults); otherwise go to IDLE.
- Outputs are decoded from the registered state only; there is no combinational path from inputs to HREADYOUT or HRESP.
- Log update on acc:
  - If ERR_VALID=0: capture ERR_ADDR and ERR_WRITE from HADDR and HWRITE, and set ERR_VALID.
  - If ERR_VALID=1: ERR_ADDR and ERR_WRITE hold, and ERR_OVF is set.
  - ERR_CNT increments on every acc and saturates at 2^CNT_WIDTH-1.
- ERR_CLR clears ERR_VALID, ERR_OVF and ERR_CNT. ERR_ADDR and ERR_WRITE hold.
- ERR_CLR and acc in the same cycle: the new fault wins. Result is ERR_VALID=1, new address captured, ERR_OVF=0, ERR_CNT=1.
- ERR_CLR has no effect on the response FSM.

## Timing
- Reset values: state IDLE, HREADYOUT=1, HRESP=2'b00, wcnt=0, ERR_VALID=0, ERR_ADDR=0, ERR_WRITE=0, ERR_OVF=0, ERR_CNT=0, ERR_IRQ=0.
- Reset asserted mid-response returns the FSM to IDLE immediately (asynchronously).
- Fault latency: the data phase lasts WAIT_STATES+2 cycles after the accept edge.
  - WAIT_STATES cycles of HREADYOUT=0 with OKAY.
  - One cycle of HREADYOUT=0 with ERROR.
  - One cycle of HREADYOUT=1 with ERROR.
- Log outputs update on the accept edge, i.e. the first data-phase cycle.
- ERR_IRQ rises in that same cycle and falls the cycle after ERR_CLR.
- OKAY for IDLE/BUSY, or for transfers with HSEL=0: HREADYOUT remains 1 and there is no state change.

## Configuration
- Macro: L2_AHB_ERR_SLAVE_LOG_EN.
- Defined: the log registers, ERR_CNT and ERR_IRQ are implemented as described above.
- Undefined: no log flops are built. ERR_VALID, ERR_ADDR, ERR_WRITE, ERR_OVF, ERR_CNT and ERR_IRQ are tied to 0, and ERR_CLR, HADDR and HWRITE are unused. The response FSM is unchanged.

## Test plan
- Reset: assert HRESET mid-WAIT with WAIT_STATES=3 -> HREADYOUT=1 and HRESP=00 immediately; all log outputs read 0.
- Single fault, WAIT_STATES=0: NONSEQ, HSEL=1, HADDR=0x4000_0010, HWRITE=1 -> HREADYOUT sequence 0,1 with HRESP 01,01. ERR_ADDR=0x4000_0010, ERR_WRITE=1, ERR_CNT=1, ERR_IRQ=1.
- Wait states, WAIT_STATES=3: one fault -> HREADYOUT 0,0,0,0,1 with HRESP 00,00,00,01,01, then IDLE.
- Back-to-back: a second NONSEQ at 0x4000_0020, accepted in ERR2 -> a second full error response with no IDLE gap. ERR_ADDR stays 0x4000_0010, ERR_OVF=1, ERR_CNT=2.
- Clear collision: ERR_CLR coincident with a fault at 0x4000_0030 -> ERR_VALID=1, ERR_ADDR=0x4000_0030, ERR_OVF=0, ERR_CNT=1.
- Saturation and idle, CNT_WIDTH=2: 5 faults -> ERR_CNT=3. IDLE/BUSY with HSEL=1 -> HREADYOUT stays 1, HRESP=00, ERR_CNT unchanged.

Source files
------------

// File: rtl/l2_ahb_err_slave.sv
// ---------------------------------------------------------------------------
// l2_ahb_err_slave
// AHB default/error slave for the L2 AHB matrix. Every NONSEQ/SEQ transfer
// that reaches this slave gets the two-cycle AHB ERROR response after
// WAIT_STATES wait cycles. IDLE/BUSY transfers get a zero-wait OKAY.
//
// Optional fault log: define L2_AHB_ERR_SLAVE_LOG_EN to build the
// first-fault address/direction capture, overflow flag, saturating fault
// counter and level interrupt. Without the macro those outputs are tied to
// zero, and the response FSM is identical in both builds.
// ---------------------------------------------------------------------------
module l2_ahb_err_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0,   // legal range 0..15
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  input  logic                  ERR_CLR,
  output logic                  ERR_VALID,
  output logic [ADDR_WIDTH-1:0] ERR_ADDR,
  output logic                  ERR_WRITE,
  output logic                  ERR_OVF,
  output logic [CNT_WIDTH-1:0]  ERR_CNT,
  output logic                  ERR_IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam bit         HAS_WAIT   = (WAIT_STATES > 0);
  // Loaded on entry to WAIT; WAIT exits when the counter has reached zero,
  // so loading WAIT_STATES-1 gives exactly WAIT_STATES wait cycles.
  localparam logic [3:0] WCNT_INIT  = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        hreadyout_q, hreadyout_d;
  logic [1:0]  hresp_q, hresp_d;
  logic        accept_state_s;
  logic        acc_s;
  logic        unused_htrans_s;

  // A new transfer is only looked at when the previous data phase is done
  // (IDLE) or in its final cycle (ERR2), which is where the next address
  // phase completes on the bus.
  assign accept_state_s  = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign acc_s           = HSEL & HREADY & HTRANS[1] & accept_state_s;
  assign unused_htrans_s = HTRANS[0];

  // State register, wait counter and registered bus response.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // Next-state logic of the response FSM.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (acc_s) begin
          if (HAS_WAIT) begin
            state_d = ST_WAIT;
            wcnt_d  = WCNT_INIT;
          end else begin
            state_d = ST_ERR1;
            wcnt_d  = 4'd0;
          end
        end else begin
          state_d = ST_IDLE;
          wcnt_d  = wcnt_q;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = ST_ERR1;
          wcnt_d  = 4'd0;
        end else begin
          state_d = ST_WAIT;
          wcnt_d  = wcnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
        wcnt_d  = wcnt_q;
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  // Response decode from the next state so HREADYOUT/HRESP come straight
  // from flops; nothing on the bus inputs reaches them combinationally.
  always_comb begin
    hreadyout_d = 1'b1;
    hresp_d     = RESP_OKAY;
    case (state_d)
      ST_IDLE: begin
        hreadyout_d = 1'b1;
        hresp_d     = RESP_OKAY;
      end
      ST_WAIT: begin
        hreadyout_d = 1'b0;
        hresp_d     = RESP_OKAY;
      end
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = RESP_ERROR;
      end
      ST_ERR2: begin
        hreadyout_d = 1'b1;
        hresp_d     = RESP_ERROR;
      end
      default: begin
        hreadyout_d = 1'b1;
        hresp_d     = RESP_OKAY;
      end
    endcase
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

`ifdef L2_AHB_ERR_SLAVE_LOG_EN

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Fault counter increment that sticks at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // Fault log registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      valid_q <= 1'b0;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      write_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= {CNT_WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Log update: a fault arriving together with a clear is treated as the
  // first fault after that clear, so the clear never loses a fault.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    write_d = write_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (acc_s) begin
      if (ERR_CLR || !valid_q) begin
        valid_d = 1'b1;
        addr_d  = HADDR;
        write_d = HWRITE;
        ovf_d   = 1'b0;
      end else begin
        valid_d = 1'b1;
        addr_d  = addr_q;
        write_d = write_q;
        ovf_d   = 1'b1;
      end
      if (ERR_CLR) begin
        cnt_d = CNT_ONE;
      end else begin
        cnt_d = sat_inc(cnt_q);
      end
    end else if (ERR_CLR) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      cnt_d   = {CNT_WIDTH{1'b0}};
    end else begin
      valid_d = valid_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
    end
  end

  assign ERR_VALID = valid_q;
  assign ERR_ADDR  = addr_q;
  assign ERR_WRITE = write_q;
  assign ERR_OVF   = ovf_q;
  assign ERR_CNT   = cnt_q;
  assign ERR_IRQ   = valid_q;

`else

  logic unused_log_s;

  // Log inputs have no function in this build.
  assign unused_log_s = ^{ERR_CLR, HADDR, HWRITE};

  assign ERR_VALID = 1'b0;
  assign ERR_ADDR  = {ADDR_WIDTH{1'b0}};
  assign ERR_WRITE = 1'b0;
  assign ERR_OVF   = 1'b0;
  assign ERR_CNT   = {CNT_WIDTH{1'b0}};
  assign ERR_IRQ   = 1'b0;

`endif

endmodule
